// File: rtl/hier_cnt_pkg.sv
// Shared types and constants for the two-level cascaded counter.
package hier_cnt_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_t;

   localparam logic ZERO = 1'b0;
   localparam logic ONE  = 1'b1;

   localparam int LSB_W_DEF   = 12;
   localparam int MSB_W_DEF   = 3;
   localparam int LSB_MAX_DEF = 3999;

endpackage

// File: rtl/hier_cnt_next.sv
// Combinational next-count for the LSB/MSB cascade, applied only when enabled.
module hier_cnt_next
   import hier_cnt_pkg::cnt_mode_t, hier_cnt_pkg::CNT_WRAP, hier_cnt_pkg::CNT_SAT,
          hier_cnt_pkg::ZERO, hier_cnt_pkg::ONE,
          hier_cnt_pkg::LSB_W_DEF, hier_cnt_pkg::MSB_W_DEF, hier_cnt_pkg::LSB_MAX_DEF;
#(
   parameter int        LSB_W   = LSB_W_DEF,
   parameter int        MSB_W   = MSB_W_DEF,
   parameter int        LSB_MAX = LSB_MAX_DEF,
   parameter cnt_mode_t MODE    = CNT_WRAP
) (
   input  logic [LSB_W-1:0] lsb,
   input  logic [MSB_W-1:0] msb,
   input  logic             en,
   output logic [LSB_W-1:0] lsb_nxt,
   output logic [MSB_W-1:0] msb_nxt,
   output logic             wrap,
   output logic             ovf,
   output logic             err
);

   localparam logic [LSB_W-1:0] LSB_TERM = LSB_W'(LSB_MAX);

   always_comb begin
      lsb_nxt = lsb;
      msb_nxt = msb;
      wrap    = ZERO;
      ovf     = ZERO;
      err     = ZERO;
      if (en) begin
         if (lsb < LSB_TERM) begin
            lsb_nxt = lsb + LSB_W'(1);
         end else if (lsb == LSB_TERM) begin
            if (!(&msb)) begin
               lsb_nxt = '0;
               msb_nxt = msb + MSB_W'(1);
               wrap    = ONE;
            end else if (MODE == CNT_SAT) begin
               // Saturated: both fields pinned at their maxima, only overflow reported.
               ovf     = ONE;
            end else begin
               lsb_nxt = '0;
               msb_nxt = '0;
               wrap    = ONE;
               ovf     = ONE;
            end
         end else begin
            err = ONE;
         end
      end
   end

endmodule

// File: rtl/hier_cnt_seq.sv
// Registered LSB/MSB cascaded counter with clear/load priority and sticky range error.
module hier_cnt_seq
   import hier_cnt_pkg::cnt_mode_t, hier_cnt_pkg::CNT_WRAP,
          hier_cnt_pkg::ZERO, hier_cnt_pkg::ONE,
          hier_cnt_pkg::LSB_W_DEF, hier_cnt_pkg::MSB_W_DEF, hier_cnt_pkg::LSB_MAX_DEF;
#(
   parameter int        LSB_W   = LSB_W_DEF,
   parameter int        MSB_W   = MSB_W_DEF,
   parameter int        LSB_MAX = LSB_MAX_DEF,
   parameter cnt_mode_t MODE    = CNT_WRAP
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [LSB_W-1:0] load_lsb_i,
   input  logic [MSB_W-1:0] load_msb_i,
   input  logic             err_clr_i,
   output logic [LSB_W-1:0] lsb_cnt_o,
   output logic [MSB_W-1:0] msb_cnt_o,
   output logic             lsb_wrap_o,
   output logic             msb_ovf_o,
   output logic             lsb_cnt_err_o
);

   if (longint'(LSB_MAX) > ((longint'(1) << LSB_W) - 1)) begin : g_bad_lsb_max
      $error("LSB_MAX does not fit in LSB_W bits");
   end

   logic [LSB_W-1:0] lsb_nxt;
   logic [MSB_W-1:0] msb_nxt;
   logic             wrap_nxt;
   logic             ovf_nxt;
   logic             err_nxt;
   logic             err_set;

   hier_cnt_next #(
      .LSB_W   (LSB_W),
      .MSB_W   (MSB_W),
      .LSB_MAX (LSB_MAX),
      .MODE    (MODE)
   ) u_next (
      .lsb     (lsb_cnt_o),
      .msb     (msb_cnt_o),
      .en      (en_i),
      .lsb_nxt (lsb_nxt),
      .msb_nxt (msb_nxt),
      .wrap    (wrap_nxt),
      .ovf     (ovf_nxt),
      .err     (err_nxt)
   );

   // Clear and load pre-empt the increment, so they cannot raise an error.
   assign err_set = err_nxt & ~clr_i & ~load_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lsb_cnt_o     <= '0;
         msb_cnt_o     <= '0;
         lsb_wrap_o    <= ZERO;
         msb_ovf_o     <= ZERO;
         lsb_cnt_err_o <= ZERO;
      end else begin
         lsb_wrap_o <= ZERO;
         msb_ovf_o  <= ZERO;
         if (clr_i) begin
            lsb_cnt_o <= '0;
            msb_cnt_o <= '0;
         end else if (load_i) begin
            lsb_cnt_o <= load_lsb_i;
            msb_cnt_o <= load_msb_i;
         end else begin
            lsb_cnt_o  <= lsb_nxt;
            msb_cnt_o  <= msb_nxt;
            lsb_wrap_o <= wrap_nxt;
            msb_ovf_o  <= ovf_nxt;
         end
         if (err_set) begin
            lsb_cnt_err_o <= ONE;
         end else if (err_clr_i) begin
            lsb_cnt_err_o <= ZERO;
         end
      end
   end

endmodule

// File: tb/tb_hier_cnt_seq.sv
// Directed bench for hier_cnt_seq: wrap-mode and saturate-mode instances driven in lockstep.
module tb_hier_cnt_seq;
   import hier_cnt_pkg::CNT_WRAP, hier_cnt_pkg::CNT_SAT;

   localparam int LW = 12;
   localparam int MW = 3;
   localparam int VW = LW + MW + 3;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          en_i = 1'b0, clr_i = 1'b0, load_i = 1'b0, err_clr_i = 1'b0;
   logic [LW-1:0] load_lsb_i = '0;
   logic [MW-1:0] load_msb_i = '0;

   logic [LW-1:0] lsb_w, lsb_s;
   logic [MW-1:0] msb_w, msb_s;
   logic          wrap_w, wrap_s, ovf_w, ovf_s, err_w, err_s;
   logic [VW-1:0] obs_w, obs_s;

   logic [VW-1:0] exp_w_q[$];
   logic [VW-1:0] exp_s_q[$];
   int            errors = 0;
   int            checks = 0;

   always #5 clk_i = ~clk_i;

   hier_cnt_seq #(.LSB_W(LW), .MSB_W(MW), .LSB_MAX(3999), .MODE(CNT_WRAP)) u_wrap (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .load_i(load_i),
      .load_lsb_i(load_lsb_i), .load_msb_i(load_msb_i), .err_clr_i(err_clr_i),
      .lsb_cnt_o(lsb_w), .msb_cnt_o(msb_w), .lsb_wrap_o(wrap_w), .msb_ovf_o(ovf_w),
      .lsb_cnt_err_o(err_w)
   );

   hier_cnt_seq #(.LSB_W(LW), .MSB_W(MW), .LSB_MAX(3999), .MODE(CNT_SAT)) u_sat (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .load_i(load_i),
      .load_lsb_i(load_lsb_i), .load_msb_i(load_msb_i), .err_clr_i(err_clr_i),
      .lsb_cnt_o(lsb_s), .msb_cnt_o(msb_s), .lsb_wrap_o(wrap_s), .msb_ovf_o(ovf_s),
      .lsb_cnt_err_o(err_s)
   );

   assign obs_w = {lsb_w, msb_w, wrap_w, ovf_w, err_w};
   assign obs_s = {lsb_s, msb_s, wrap_s, ovf_s, err_s};

   // Expected vector layout: {lsb, msb, wrap, ovf, err}
   function automatic logic [VW-1:0] pk(input int l, input int m, input bit w, input bit o,
                                        input bit e);
      return {LW'(l), MW'(m), w, o, e};
   endfunction

   task automatic check(input string tag);
      logic [VW-1:0] ew, es;
      checks++;
      if (exp_w_q.size() == 0) ew = 'x; else ew = exp_w_q.pop_front();
      assert (obs_w === ew) else begin
         errors++;
         $error("FAIL %s wrap-mode observed=%h expected=%h", tag, obs_w, ew);
      end
      checks++;
      if (exp_s_q.size() == 0) es = 'x; else es = exp_s_q.pop_front();
      assert (obs_s === es) else begin
         errors++;
         $error("FAIL %s sat-mode observed=%h expected=%h", tag, obs_s, es);
      end
   endtask

   task automatic step(input string tag, input bit en, input bit clr, input bit ld,
                       input int ll, input int lm, input bit ec,
                       input logic [VW-1:0] ew, input logic [VW-1:0] es);
      en_i       = en;
      clr_i      = clr;
      load_i     = ld;
      load_lsb_i = LW'(ll);
      load_msb_i = MW'(lm);
      err_clr_i  = ec;
      exp_w_q.push_back(ew);
      exp_s_q.push_back(es);
      @(posedge clk_i);
      #1;
      check(tag);
   endtask

   initial begin
      int n;
      // Reset state
      #2;
      exp_w_q.push_back(pk(0, 0, 0, 0, 0));
      exp_s_q.push_back(pk(0, 0, 0, 0, 0));
      check("reset_init");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Asynchronous reset mid-count
      step("load_1234", 0, 0, 1, 1234, 2, 0, pk(1234, 2, 0, 0, 0), pk(1234, 2, 0, 0, 0));
      step("inc_1235",  1, 0, 0, 0, 0, 0,    pk(1235, 2, 0, 0, 0), pk(1235, 2, 0, 0, 0));
      #2 rst_i = 1'b1;
      #1;
      exp_w_q.push_back(pk(0, 0, 0, 0, 0));
      exp_s_q.push_back(pk(0, 0, 0, 0, 0));
      check("async_reset");
      #2 rst_i = 1'b0;
      step("resume",    1, 0, 0, 0, 0, 0,    pk(1, 0, 0, 0, 0), pk(1, 0, 0, 0, 0));

      // LSB carry into MSB
      step("load_3998", 0, 0, 1, 3998, 1, 0, pk(3998, 1, 0, 0, 0), pk(3998, 1, 0, 0, 0));
      step("inc_3999",  1, 0, 0, 0, 0, 0,    pk(3999, 1, 0, 0, 0), pk(3999, 1, 0, 0, 0));
      step("carry",     1, 0, 0, 0, 0, 0,    pk(0, 2, 1, 0, 0),    pk(0, 2, 1, 0, 0));
      step("wrap_pulse_end", 0, 0, 0, 0, 0, 0, pk(0, 2, 0, 0, 0),  pk(0, 2, 0, 0, 0));

      // MSB overflow: wrap vs saturate
      step("load_max",  0, 0, 1, 3999, 7, 0, pk(3999, 7, 0, 0, 0), pk(3999, 7, 0, 0, 0));
      step("ovf_1",     1, 0, 0, 0, 0, 0,    pk(0, 0, 1, 1, 0),    pk(3999, 7, 0, 1, 0));
      step("ovf_2",     1, 0, 0, 0, 0, 0,    pk(1, 0, 0, 0, 0),    pk(3999, 7, 0, 1, 0));
      step("ovf_3",     1, 0, 0, 0, 0, 0,    pk(2, 0, 0, 0, 0),    pk(3999, 7, 0, 1, 0));
      step("ovf_idle",  0, 0, 0, 0, 0, 0,    pk(2, 0, 0, 0, 0),    pk(3999, 7, 0, 0, 0));

      // Out-of-range LSB and sticky error
      step("load_4000", 0, 0, 1, 4000, 5, 0, pk(4000, 5, 0, 0, 0), pk(4000, 5, 0, 0, 0));
      step("err_set_1", 1, 0, 0, 0, 0, 0,    pk(4000, 5, 0, 0, 1), pk(4000, 5, 0, 0, 1));
      step("err_set_2", 1, 0, 0, 0, 0, 0,    pk(4000, 5, 0, 0, 1), pk(4000, 5, 0, 0, 1));
      step("err_sticky", 0, 0, 0, 0, 0, 0,   pk(4000, 5, 0, 0, 1), pk(4000, 5, 0, 0, 1));
      step("err_set_wins", 1, 0, 0, 0, 0, 1, pk(4000, 5, 0, 0, 1), pk(4000, 5, 0, 0, 1));
      step("err_cleared", 0, 0, 0, 0, 0, 1,  pk(4000, 5, 0, 0, 0), pk(4000, 5, 0, 0, 0));

      // Priority clr > load > en; clear leaves the error flag alone
      step("err_again", 1, 0, 0, 0, 0, 0,    pk(4000, 5, 0, 0, 1), pk(4000, 5, 0, 0, 1));
      step("load_10",   0, 0, 1, 10, 0, 0,   pk(10, 0, 0, 0, 1),   pk(10, 0, 0, 0, 1));
      step("clr_wins",  1, 1, 1, 100, 3, 0,  pk(0, 0, 0, 0, 1),    pk(0, 0, 0, 0, 1));
      step("load_wins", 1, 0, 1, 100, 3, 0,  pk(100, 3, 0, 0, 1),  pk(100, 3, 0, 0, 1));
      step("err_clr",   0, 0, 0, 0, 0, 1,    pk(100, 3, 0, 0, 0),  pk(100, 3, 0, 0, 0));
      step("inc_101",   1, 0, 0, 0, 0, 0,    pk(101, 3, 0, 0, 0),  pk(101, 3, 0, 0, 0));

      // Randomised run length from zero
      step("clr_run",   0, 1, 0, 0, 0, 0,    pk(0, 0, 0, 0, 0),    pk(0, 0, 0, 0, 0));
      n = $urandom_range(5, 20);
      for (int i = 1; i <= n; i++) begin
         step("run_inc", 1, 0, 0, 0, 0, 0,   pk(i, 0, 0, 0, 0),    pk(i, 0, 0, 0, 0));
      end
      step("run_hold",  0, 0, 0, 0, 0, 0,    pk(n, 0, 0, 0, 0),    pk(n, 0, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hier_cnt_seq.md
Name: hier_cnt_seq

Overview:
Registered two-level (LSB/MSB) cascaded counter. It is the parametrised sequential successor of the team's combinational next-count logic.
- The LSB field counts 0..LSB_MAX, then carries into the MSB field.
- The MSB field wraps or saturates according to MODE.
- Adds enable, synchronous clear, parallel load, carry/overflow pulses, and a sticky out-of-range error.
- Sits in timing/frame-counting datapaths, feeding comparators and status registers.

Parameters:
- LSB_W, 12, width of the LSB count field.
- MSB_W, 3, width of the MSB count field.
- LSB_MAX, 3999, terminal LSB value; must be ≤ 2^LSB_W-1 (elaboration assertion).
- MODE, CNT_WRAP, MSB overflow policy: CNT_WRAP or CNT_SAT, from hier_cnt_pkg::cnt_mode_t.

Ports:
- clk_i, in, 1, clock; all state updates on rising edge.
- rst_i, in, 1, reset, asynchronous, active-high.
- en_i, in, 1, count enable; one increment per cycle when high.
- clr_i, in, 1, synchronous clear of both fields.
- load_i, in, 1, synchronous parallel load.
- load_lsb_i, in, LSB_W, LSB load value.
- load_msb_i, in, MSB_W, MSB load value.
- err_clr_i, in, 1, clears the sticky error.
- lsb_cnt_o, out, LSB_W, registered LSB count.
- msb_cnt_o, out, MSB_W, registered MSB count.
- lsb_wrap_o, out, 1, one-cycle pulse: LSB rolled LSB_MAX→0.
- msb_ovf_o, out, 1, one-cycle pulse: MSB overflow attempted at all-ones.
- lsb_cnt_err_o, out, 1, sticky: increment attempted with LSB > LSB_MAX.

Behaviour:
- Reset (rst_i=1, asynchronous): lsb_cnt_o=0, msb_cnt_o=0, lsb_wrap_o=0, msb_ovf_o=0, lsb_cnt_err_o=0. Reset mid-operation aborts immediately; counting resumes on the first rising edge after rst_i deasserts.
- Priority per cycle: clr_i > load_i > en_i.
- clr_i=1: both fields become 0; pulses 0; error flag unaffected.
- load_i=1: fields take load_lsb_i/load_msb_i verbatim, including LSB > LSB_MAX; pulses 0; no range check at load.
- en_i=1, LSB < LSB_MAX: LSB+1 (modulo 2^LSB_W); MSB holds.
- en_i=1, LSB == LSB_MAX: LSB becomes 0; lsb_wrap_o=1 next cycle.
  - MSB < all-ones: MSB+1.
  - MSB == all-ones, CNT_WRAP: MSB becomes 0, msb_ovf_o=1.
  - MSB == all-ones, CNT_SAT: LSB and MSB hold at LSB_MAX/all-ones, lsb_wrap_o=0, msb_ovf_o=1 on every enabled cycle.
- en_i=1, LSB > LSB_MAX: both fields hold; lsb_cnt_err_o set to 1. The flag stays set until err_clr_i or reset.
- en_i=0 and no clr/load: hold; pulses 0.
- err_clr_i and a new error in the same cycle: the set wins, so the flag stays 1.
- Pulse outputs are registered, asserted the cycle after the causing edge and for exactly one cycle per event.
- Latency: one clock from input to count outputs. No combinational paths from inputs to outputs.
- Arithmetic: increments are width-exact (LSB_W / MSB_W); there are no carries beyond the field width other than the defined wrap.

Decomposition:
- Package hier_cnt_pkg:
  - cnt_mode_t enum {CNT_WRAP, CNT_SAT}.
  - Constants ZERO=1'b0 and ONE=1'b1.
  - Default constants LSB_W_DEF=12, MSB_W_DEF=3, LSB_MAX_DEF=3999.
  - Members imported by name, not wildcard.
- Sub-module hier_cnt_next: purely combinational always_comb next-state. It takes the current counts, en, and MODE, and produces the next counts, wrap, ovf and err terms.
- The top holds the registers, clr/load priority and the sticky error. Expected total is about 150-220 lines.

Test Plan:
- Reset: assert rst_i mid-count (LSB=1234, MSB=2) asynchronously between edges → all outputs 0 immediately, no clock edge needed.
- Carry: load LSB=3998, MSB=1, en_i=1 for 2 cycles → LSB 3999 then 0, MSB 2; lsb_wrap_o high for exactly one cycle.
- Overflow, MODE=CNT_WRAP: load LSB=3999, MSB=7, en 1 cycle → LSB=0, MSB=0, lsb_wrap_o=1, msb_ovf_o=1.
- Overflow, MODE=CNT_SAT: same stimulus held for 3 cycles → LSB=3999, MSB=7 held; msb_ovf_o=1 each cycle; lsb_wrap_o=0.
- Error: load LSB=4000, MSB=5, en 2 cycles → counts hold at 4000/5; lsb_cnt_err_o=1 and sticky after en drops. Assert err_clr_i with en still high → flag stays 1. Clear with en low → flag 0.
- Priority: clr_i, load_i and en_i all high with LSB=10 → both fields 0. Then load_i+en_i with load 100/3 → LSB=100, MSB=3, no increment.
